// File: rtl/nn_loader_pkg.sv
// nn_loader_pkg: shared states, write-enable encodings and address widths for the stream loader
package nn_loader_pkg;
  localparam int PIX_AW = 10;
  localparam int NEU_AW = 5;
  typedef enum logic [2:0] {IDLE, LD_W1, LD_B1, LD_W2, LD_B2, STREAM, DRAIN, RESULT} state_e;
  localparam logic [3:0] W_L1 = 4'b0001;
  localparam logic [3:0] W_B1 = 4'b0010;
  localparam logic [3:0] W_L2 = 4'b0100;
  localparam logic [3:0] W_B2 = 4'b1000;
  typedef struct packed {
    logic [7:0]        pixel_in;
    logic [PIX_AW-1:0] pixel_addr;
    logic [9:0]        weight_data;
    logic [NEU_AW-1:0] weight_addr;
    logic [3:0]        w;
    logic              begin_sign;
    logic              finish_sign;
  } nn_out_t;
  function automatic logic [3:0] w_sel(state_e s);
    return s == LD_W1 ? W_L1 : s == LD_B1 ? W_B1 : s == LD_W2 ? W_L2 : s == LD_B2 ? W_B2 : 4'b0000;
  endfunction
endpackage

// File: rtl/nn_stream_loader_if.sv
// nn_stream_loader_if: weight/pixel/result streams plus the core-facing load and compute bus
interface nn_stream_loader_if;
  logic [9:0] wt_data;
  logic       wt_valid;
  logic       wt_ready;
  logic [7:0] px_data;
  logic       px_valid;
  logic       px_ready;
  logic [3:0] res_data;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] nn_pixel_in;
  logic [9:0] nn_pixel_addr;
  logic [9:0] nn_weight_data;
  logic [4:0] nn_weight_addr;
  logic [3:0] nn_w;
  logic       nn_begin_sign;
  logic       nn_finish_sign;
  logic [3:0] nn_result;
  modport slave (
    input  wt_data, wt_valid, px_data, px_valid, res_ready, nn_result,
    output wt_ready, px_ready, res_data, res_valid,
    output nn_pixel_in, nn_pixel_addr, nn_weight_data, nn_weight_addr, nn_w,
    output nn_begin_sign, nn_finish_sign
  );
  modport master (
    output wt_data, wt_valid, px_data, px_valid, res_ready, nn_result,
    input  wt_ready, px_ready, res_data, res_valid,
    input  nn_pixel_in, nn_pixel_addr, nn_weight_data, nn_weight_addr, nn_w,
    input  nn_begin_sign, nn_finish_sign
  );
endinterface

// File: rtl/nn_addr_counter.sv
// nn_addr_counter: two-level inner/outer address counter; inner runs fastest and both wrap at their limits
module nn_addr_counter
  import nn_loader_pkg::*;
#(
  parameter int IW = PIX_AW,
  parameter int OW = NEU_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [IW-1:0] inner_max_i,
  input  logic [OW-1:0] outer_max_i,
  output logic [IW-1:0] inner_o,
  output logic [OW-1:0] outer_o,
  output logic          last_o
);
  logic [IW-1:0] inner_q, inner_d;
  logic [OW-1:0] outer_q, outer_d;
  logic          wrap;
  always_comb begin
    wrap    = inner_q == inner_max_i;
    last_o  = wrap && outer_q == outer_max_i;
    inner_d = clr_i ? '0 : !en_i ? inner_q : wrap ? '0 : inner_q + IW'(1);
    outer_d = clr_i ? '0 : !(en_i && wrap) ? outer_q : last_o ? '0 : outer_q + OW'(1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inner_q <= '0;
      outer_q <= '0;
    end else begin
      inner_q <= inner_d;
      outer_q <= outer_d;
    end
  end
  assign inner_o = inner_q;
  assign outer_o = outer_q;
endmodule

// File: rtl/nn_stream_loader.sv
// nn_stream_loader: writes the weight/bias stream into the core's four parameter memories,
// then frames pixel streams into the core and returns the sampled class over valid/ready.
module nn_stream_loader
  import nn_loader_pkg::*;
#(
  parameter int NPIX         = 784,
  parameter int N1           = 20,
  parameter int N2           = 10,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_start_i,
  output logic weights_loaded_o,
  output logic busy_o,
  nn_stream_loader_if.slave bus
);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [PIX_AW-1:0] PIX_MAX = PIX_AW'(NPIX - 1);
  localparam logic [PIX_AW-1:0] L2_MAX  = PIX_AW'(N2 - 1);
  localparam logic [NEU_AW-1:0] N1_MAX  = NEU_AW'(N1 - 1);
  localparam logic [NEU_AW-1:0] N2_MAX  = NEU_AW'(N2 - 1);
  state_e            state_q, state_d;
  nn_out_t           nn_q, nn_d;
  logic              loaded_q, loaded_d;
  logic              rvalid_q, rvalid_d;
  logic [3:0]        rdata_q, rdata_d;
  logic [DW-1:0]     drain_q, drain_d;
  logic              ld, px_rdy, wt_beat, px_beat, clr, last;
  logic [PIX_AW-1:0] inner, inner_max;
  logic [NEU_AW-1:0] outer, outer_max;
  assign ld        = state_q inside {LD_W1, LD_B1, LD_W2, LD_B2};
  assign px_rdy    = (state_q == IDLE && loaded_q && !load_start_i) || state_q == STREAM;
  assign wt_beat   = ld && bus.wt_valid;
  assign px_beat   = px_rdy && bus.px_valid;
  assign clr       = state_q == IDLE && load_start_i;
  // Outside the load states the counter walks the image: inner over pixels, outer pinned at 0
  assign inner_max = state_q == LD_W2 ? L2_MAX : (state_q == LD_B1 || state_q == LD_B2) ? '0 : PIX_MAX;
  assign outer_max = state_q == LD_B2 ? N2_MAX : ld ? N1_MAX : '0;
  nn_addr_counter #(.IW(PIX_AW), .OW(NEU_AW)) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (clr),
    .en_i       (wt_beat || px_beat),
    .inner_max_i(inner_max),
    .outer_max_i(outer_max),
    .inner_o    (inner),
    .outer_o    (outer),
    .last_o     (last)
  );
  always_comb begin
    state_d            = state_q;
    nn_d               = nn_q;
    nn_d.w             = wt_beat ? w_sel(state_q) : 4'b0000;
    nn_d.weight_data   = wt_beat ? bus.wt_data : nn_q.weight_data;
    nn_d.weight_addr   = wt_beat ? outer : nn_q.weight_addr;
    nn_d.pixel_addr    = (wt_beat || px_beat) ? inner : nn_q.pixel_addr;
    nn_d.pixel_in      = px_beat ? bus.px_data : 8'd0;
    nn_d.begin_sign    = px_beat && state_q == IDLE;
    nn_d.finish_sign   = state_q == DRAIN && drain_q == '0;
    loaded_d           = loaded_q;
    rvalid_d           = rvalid_q;
    rdata_d            = rdata_q;
    drain_d            = state_q == DRAIN ? drain_q + DW'(1) : '0;
    case (state_q)
      IDLE:   if (load_start_i) begin
                state_d  = LD_W1;
                loaded_d = 1'b0;
              end else if (px_beat) state_d = last ? DRAIN : STREAM;
      LD_W1:  if (wt_beat && last) state_d = LD_B1;
      LD_B1:  if (wt_beat && last) state_d = LD_W2;
      LD_W2:  if (wt_beat && last) state_d = LD_B2;
      LD_B2:  if (wt_beat && last) begin
                state_d  = IDLE;
                loaded_d = 1'b1;
              end
      STREAM: if (px_beat && last) state_d = DRAIN;
      // Count 0 is the cycle the last pixel is on the bus; counts 1..DRAIN_CYCLES start at finish_sign
      DRAIN:  if (drain_q == DW'(DRAIN_CYCLES)) begin
                rdata_d  = bus.nn_result;
                rvalid_d = 1'b1;
                state_d  = RESULT;
              end
      RESULT: if (bus.res_ready) begin
                rvalid_d = 1'b0;
                state_d  = IDLE;
              end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      nn_q     <= '0;
      loaded_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      drain_q  <= '0;
    end else begin
      state_q  <= state_d;
      nn_q     <= nn_d;
      loaded_q <= loaded_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      drain_q  <= drain_d;
    end
  end
  assign bus.wt_ready       = ld;
  assign bus.px_ready       = px_rdy;
  assign bus.res_data       = rdata_q;
  assign bus.res_valid      = rvalid_q;
  assign bus.nn_pixel_in    = nn_q.pixel_in;
  assign bus.nn_pixel_addr  = nn_q.pixel_addr;
  assign bus.nn_weight_data = nn_q.weight_data;
  assign bus.nn_weight_addr = nn_q.weight_addr;
  assign bus.nn_w           = nn_q.w;
  assign bus.nn_begin_sign  = nn_q.begin_sign;
  assign bus.nn_finish_sign = nn_q.finish_sign;
  assign weights_loaded_o   = loaded_q;
  assign busy_o             = state_q != IDLE;
endmodule

// File: doc/nn_stream_loader.md
Name: nn_stream_loader

Overview:
- Host-side sequencer that drives the inference core's load and compute interface.
- Accepts a weight/bias word stream and writes it into the core's four parameter memories in a fixed order. It generates every address and one-hot write enable.
- Accepts a pixel stream and presents it to the core with addresses and begin/finish framing. After a fixed drain, it captures the core's class result and returns it over a valid/ready handshake.

Parameters:
- NPIX, 784, pixels per image, also layer-1 fan-in (max 1024)
- N1, 20, hidden neurons (max 32)
- N2, 10, output classes (max 16)
- DRAIN_CYCLES, 8, cycles from finish_sign to result sample (min 1)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- load_start  in  1  pulse that starts a parameter load; honoured only in IDLE
- wt_data  in  10  parameter word
- wt_valid  in  1  wt_data valid
- wt_ready  out  1  loader accepts wt_data
- px_data  in  8  pixel
- px_valid  in  1  px_data valid
- px_ready  out  1  loader accepts px_data
- res_data  out  4  classified digit
- res_valid  out  1  res_data valid
- res_ready  in  1  consumer accepts res_data
- weights_loaded  out  1  full parameter set written since reset
- busy  out  1  state is not IDLE
- nn_pixel_in  out  8  pixel to core
- nn_pixel_addr  out  10  pixel / inner address to core
- nn_weight_data  out  10  parameter word to core
- nn_weight_addr  out  5  neuron / outer address to core
- nn_w  out  4  one-hot memory write enable: [0] L1 weights, [1] L1 bias, [2] L2 weights, [3] L2 bias
- nn_begin_sign  out  1  image start
- nn_finish_sign  out  1  image end
- nn_result  in  4  core class output

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All outputs 0.
  - State IDLE; weights_loaded 0; all counters 0.
- States: IDLE, LD_W1, LD_B1, LD_W2, LD_B2, STREAM, DRAIN, RESULT.
- All nn_* outputs are registered. An accepted beat at edge t appears on the nn_* outputs during cycle t+1.
- Parameter load:
  - IDLE with load_start=1 -> LD_W1. Inner and outer counters are cleared. weights_loaded drops to 0.
  - wt_ready is 1 in every LD_* state and 0 elsewhere.
  - LD_W1: beat writes nn_w=0001, pixel_addr=inner (0..NPIX-1), weight_addr=outer (0..N1-1). Inner is fastest. The last beat advances to LD_B1.
  - LD_B1: nn_w=0010, weight_addr=0..N1-1, pixel_addr=0.
  - LD_W2: nn_w=0100, pixel_addr=inner (0..N2-1), weight_addr=outer (0..N1-1). Inner is fastest.
  - LD_B2: nn_w=1000, weight_addr=0..N2-1. The last beat sets weights_loaded=1 and returns to IDLE.
  - Total beats = NPIX*N1 + N1 + N2*N1 + N2.
  - A cycle with no beat drives nn_w=0000 and holds the address and data outputs.
- Inference:
  - px_ready=1 in IDLE when weights_loaded=1 and load_start=0, and in STREAM. Otherwise px_ready=0.
  - load_start takes priority over a pixel beat in the same IDLE cycle.
  - First beat in IDLE -> STREAM. Next cycle: nn_pixel_in=px_data, nn_pixel_addr=0, nn_begin_sign=1 for exactly one cycle.
  - Each further beat k drives nn_pixel_addr=k.
  - Gap cycles (px_valid=0 in STREAM) drive nn_pixel_in=0 and hold nn_pixel_addr, so the core's MAC adds zero.
  - Beat NPIX-1 -> DRAIN. nn_finish_sign=1 for one cycle in the cycle after that pixel is presented (t+2). nn_pixel_in returns to 0.
  - DRAIN counts DRAIN_CYCLES cycles starting with the finish_sign cycle. It then samples nn_result into res_data, sets res_valid=1, and enters RESULT.
  - RESULT: res_data is held stable while res_valid=1 and res_ready=0. When res_valid=1 and res_ready=1: res_valid drops next cycle, state -> IDLE.
  - res_ready is ignored while res_valid=0.
- load_start outside IDLE is ignored, with no queueing.
- Counter wrap: each counter resets to 0 exactly at its terminal count. Addresses never exceed NPIX-1, N1-1 or N2-1.
- Async reset mid-load or mid-image aborts with no partial output.
  - After reset, weights_loaded=0, so a full reload is required before the next image.

Decomposition:
- Package nn_loader_pkg holds:
  - the state enum;
  - the nn_w one-hot constants W_L1, W_B1, W_L2, W_B2;
  - localparam address widths: PIX_AW=10, NEU_AW=5.
- One sub-module, nn_addr_counter: a two-level inner/outer counter with enable, parameterised limits, and last/wrap flags. It is reused by the LD_* states and STREAM.

Test Plan (NPIX=4, N1=3, N2=2, DRAIN_CYCLES=5 unless noted):
- Reset then load_start, 26 back-to-back words 0..25 -> observed writes:
  - nn_w=0001 for words 0..11 at (pix,neu)=(0,0),(1,0)..(3,2);
  - nn_w=0010 for 12..14 at neu 0..2;
  - nn_w=0100 for 15..20 at (pix,neu)=(0,0),(1,0)..(1,2);
  - nn_w=1000 for 21..22 at neu 0..1;
  - words 23..25 are not accepted (wt_ready=0);
  - weights_loaded=1 after word 22.
- Load with wt_valid toggling every other cycle -> nn_w=0000 on idle cycles; same address/data sequence as the previous scenario.
- Image 10,20,30,40 back-to-back -> addrs 0..3 on consecutive cycles; begin_sign with addr 0; finish_sign one cycle after addr 3. nn_result=7 held; res_data=7 and res_valid rise 5 cycles after finish_sign.
- Image with two idle cycles after pixel 1 -> nn_pixel_in=0 and addr=1 held for 2 cycles; finish_sign timing is relative to the last pixel.
- res_ready held low 10 cycles -> res_valid and res_data stable; px_ready=0; load_start ignored. res_ready high -> IDLE next cycle.
- rst_n low mid-STREAM (after pixel 2) -> all outputs 0 asynchronously; weights_loaded=0. A pixel presented afterward gets px_ready=0.
